// File: rtl/remote_comm.sv
// remote_comm: host-side UART link to the flight controller.
// Transmit side sends one command byte and a 16-bit data word as three
// back-to-back 8N1 frames (cmd, data[15:8], data[7:0]). Receive side
// captures single-byte responses sampled at mid-bit.
//
// Handshakes: send_cmd is a one-cycle request, honoured only while the
// transmitter is idle; cmd_sent stays high from the end of the last stop
// bit until the next accepted request. resp_rdy goes high together with a
// valid resp and stays high until clr_resp_rdy or the next start bit; a
// set in the same cycle as a clear leaves resp_rdy high.
// rst_n is an active-high asynchronous reset despite its name.
module remote_comm #(
  parameter int BAUD_DIV = 2604
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        RX,
  output logic        TX,
  input  logic [7:0]  cmd,
  input  logic [15:0] data,
  input  logic        send_cmd,
  output logic        cmd_sent,
  output logic [7:0]  resp,
  output logic        resp_rdy,
  input  logic        clr_resp_rdy
);

  localparam int BW = (BAUD_DIV > 2) ? $clog2(BAUD_DIV) : 1;
  localparam logic [BW-1:0] BAUD_LAST = BW'(BAUD_DIV - 1);
  localparam logic [BW-1:0] BAUD_PRE  = BW'(BAUD_DIV - 2);
  localparam logic [BW-1:0] HALF_LAST = BW'(BAUD_DIV / 2 - 1);

  typedef enum logic [2:0] {
    TX_IDLE,
    TX_LOAD,
    TX_SHIFT,
    TX_NEXT,
    TX_DONE
  } tx_state_e;

  typedef enum logic {
    RX_IDLE,
    RX_RECV
  } rx_state_e;

  // transmitter state
  tx_state_e   tx_state_q, tx_state_d;
  logic [23:0] hold_q, hold_d;
  logic [9:0]  sh_q, sh_d;
  logic [BW-1:0] tbaud_q, tbaud_d;
  logic [3:0]  tbit_q, tbit_d;
  logic [1:0]  tbyte_q, tbyte_d;
  logic        cmd_sent_q, cmd_sent_d;
  logic [7:0]  next_byte;

  // receiver state
  rx_state_e   rx_state_q, rx_state_d;
  logic        rx_s1_q, rx_s1_d;
  logic        rx_s2_q, rx_s2_d;
  logic        rx_prev_q, rx_prev_d;
  logic [BW-1:0] rbaud_q, rbaud_d;
  logic [3:0]  rbit_q, rbit_d;
  logic [7:0]  rsh_q, rsh_d;
  logic [7:0]  resp_q, resp_d;
  logic        resp_rdy_q, resp_rdy_d;
  logic        rx_fall, rx_sample, rx_set, rx_start;

  // The line idles at the shift register's LSB, which resets to all ones.
  assign TX       = sh_q[0];
  assign cmd_sent = cmd_sent_q;
  assign resp     = resp_q;
  assign resp_rdy = resp_rdy_q;

  // Byte following the one currently on the line.
  assign next_byte = (tbyte_q == 2'd0) ? hold_q[15:8] : hold_q[7:0];

  // Transmit next-state: NEXT occupies the final clock of each stop bit so
  // the following start bit begins with no idle gap.
  always_comb begin
    tx_state_d = tx_state_q;
    hold_d     = hold_q;
    sh_d       = sh_q;
    tbaud_d    = tbaud_q;
    tbit_d     = tbit_q;
    tbyte_d    = tbyte_q;
    cmd_sent_d = cmd_sent_q;
    case (tx_state_q)
      TX_IDLE: begin
        if (send_cmd) begin
          hold_d     = {cmd, data};
          cmd_sent_d = 1'b0;
          tbyte_d    = 2'd0;
          tx_state_d = TX_LOAD;
        end
      end
      TX_LOAD: begin
        sh_d       = {1'b1, hold_q[23:16], 1'b0};
        tbaud_d    = '0;
        tbit_d     = 4'd0;
        tx_state_d = TX_SHIFT;
      end
      TX_SHIFT: begin
        if (tbit_q == 4'd9 && tbaud_q == BAUD_PRE) begin
          tx_state_d = TX_NEXT;
        end else if (tbaud_q == BAUD_LAST) begin
          tbaud_d = '0;
          tbit_d  = tbit_q + 4'd1;
          sh_d    = {1'b1, sh_q[9:1]};
        end else begin
          tbaud_d = tbaud_q + BW'(1);
        end
      end
      TX_NEXT: begin
        tbaud_d = '0;
        tbit_d  = 4'd0;
        if (tbyte_q == 2'd2) begin
          sh_d       = '1;
          cmd_sent_d = 1'b1;
          tx_state_d = TX_DONE;
        end else begin
          sh_d       = {1'b1, next_byte, 1'b0};
          tbyte_d    = tbyte_q + 2'd1;
          tx_state_d = TX_SHIFT;
        end
      end
      TX_DONE: begin
        tx_state_d = TX_IDLE;
      end
      default: begin
        tx_state_d = TX_IDLE;
      end
    endcase
  end

  // Transmit registers; reset forces TX high immediately.
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      tx_state_q <= TX_IDLE;
      hold_q     <= '0;
      sh_q       <= '1;
      tbaud_q    <= '0;
      tbit_q     <= '0;
      tbyte_q    <= '0;
      cmd_sent_q <= 1'b0;
    end else begin
      tx_state_q <= tx_state_d;
      hold_q     <= hold_d;
      sh_q       <= sh_d;
      tbaud_q    <= tbaud_d;
      tbit_q     <= tbit_d;
      tbyte_q    <= tbyte_d;
      cmd_sent_q <= cmd_sent_d;
    end
  end

  assign rx_fall   = rx_prev_q & ~rx_s2_q;
  assign rx_sample = (rbit_q == 4'd0) ? (rbaud_q == HALF_LAST) : (rbaud_q == BAUD_LAST);

  // Receive next-state: sample 0 is mid start bit, 1..8 data, 9 the stop bit.
  always_comb begin
    rx_state_d = rx_state_q;
    rx_s1_d    = RX;
    rx_s2_d    = rx_s1_q;
    rx_prev_d  = rx_s2_q;
    rbaud_d    = rbaud_q;
    rbit_d     = rbit_q;
    rsh_d      = rsh_q;
    resp_d     = resp_q;
    rx_set     = 1'b0;
    rx_start   = 1'b0;
    case (rx_state_q)
      RX_IDLE: begin
        if (rx_fall) begin
          rx_start   = 1'b1;
          rbaud_d    = '0;
          rbit_d     = 4'd0;
          rx_state_d = RX_RECV;
        end
      end
      RX_RECV: begin
        if (rx_sample) begin
          rbaud_d = '0;
          if (rbit_q == 4'd9) begin
            rx_set     = 1'b1;
            resp_d     = rsh_q;
            rbit_d     = 4'd0;
            rx_state_d = RX_IDLE;
          end else begin
            if (rbit_q != 4'd0) begin
              rsh_d = {rx_s2_q, rsh_q[7:1]};
            end
            rbit_d = rbit_q + 4'd1;
          end
        end else begin
          rbaud_d = rbaud_q + BW'(1);
        end
      end
      default: begin
        rx_state_d = RX_IDLE;
      end
    endcase
    if (rx_set) begin
      resp_rdy_d = 1'b1;
    end else if (clr_resp_rdy || rx_start) begin
      resp_rdy_d = 1'b0;
    end else begin
      resp_rdy_d = resp_rdy_q;
    end
  end

  // Receive registers; synchroniser flops reset to the idle-high level.
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      rx_state_q <= RX_IDLE;
      rx_s1_q    <= 1'b1;
      rx_s2_q    <= 1'b1;
      rx_prev_q  <= 1'b1;
      rbaud_q    <= '0;
      rbit_q     <= '0;
      rsh_q      <= '0;
      resp_q     <= '0;
      resp_rdy_q <= 1'b0;
    end else begin
      rx_state_q <= rx_state_d;
      rx_s1_q    <= rx_s1_d;
      rx_s2_q    <= rx_s2_d;
      rx_prev_q  <= rx_prev_d;
      rbaud_q    <= rbaud_d;
      rbit_q     <= rbit_d;
      rsh_q      <= rsh_d;
      resp_q     <= resp_d;
      resp_rdy_q <= resp_rdy_d;
    end
  end

endmodule

// File: tb/tb_remote_comm.sv
// Bench for remote_comm: TX frames are decoded by a line monitor and
// compared with bytes queued when each command is issued; RX responses are
// queued when the bench UART drives them and compared when resp_rdy rises.
module tb_remote_comm;
  localparam int B = 16;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        RX = 1'b1;
  logic        TX;
  logic [7:0]  cmd = 8'h00;
  logic [15:0] data = 16'h0000;
  logic        send_cmd = 1'b0;
  logic        cmd_sent;
  logic [7:0]  resp;
  logic        resp_rdy;
  logic        clr_resp_rdy = 1'b0;

  int checks = 0;
  int failures = 0;
  logic [7:0] tx_exp_q[$];
  logic [7:0] rx_exp_q[$];

  remote_comm #(.BAUD_DIV(B)) dut (
    .clk(clk), .rst_n(rst_n), .RX(RX), .TX(TX),
    .cmd(cmd), .data(data), .send_cmd(send_cmd), .cmd_sent(cmd_sent),
    .resp(resp), .resp_rdy(resp_rdy), .clr_resp_rdy(clr_resp_rdy)
  );

  // clock and watchdog
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  // TX line monitor: a frame is 10 bits of B clocks each, every clock of a
  // bit must hold the same level; the next frame may start right after.
  int ph;
  logic [9:0] fbits;
  bit fbad;
  bit mon_act = 0;
  always @(negedge clk) begin
    if (rst_n) begin
      mon_act = 0;
    end else if (!mon_act) begin
      if (TX === 1'b0) begin
        mon_act = 1;
        ph = 0;
        fbad = 0;
        fbits = '1;
        fbits[0] = 1'b0;
      end
    end else begin
      ph++;
      if (ph % B == 0) fbits[ph / B] = TX;
      else if (TX !== fbits[ph / B]) fbad = 1;
      if (ph == 10 * B - 1) begin
        mon_act = 0;
        check("tx_frame_shape", {29'd0, fbad, fbits[0], fbits[9]}, 32'd1);
        if (tx_exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL tx_extra_frame actual=0x%0h required=none", fbits[8:1]);
        end else begin
          check("tx_byte", {24'd0, fbits[8:1]}, {24'd0, tx_exp_q.pop_front()});
        end
      end
    end
  end

  // RX response monitor
  logic rdy_prev = 1'b0;
  always @(negedge clk) begin
    if (!rst_n && resp_rdy === 1'b1 && !rdy_prev) begin
      if (rx_exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL rx_extra_resp actual=0x%0h required=none", resp);
      end else begin
        check("rx_resp", {24'd0, resp}, {24'd0, rx_exp_q.pop_front()});
      end
    end
    rdy_prev = resp_rdy;
  end

  // bench UART driving RX, 8N1 with B clocks per bit
  task automatic uart_send(input logic [7:0] b, input bit push);
    if (push) rx_exp_q.push_back(b);
    @(negedge clk);
    RX = 1'b0;
    repeat (B) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      RX = b[i];
      repeat (B) @(negedge clk);
    end
    RX = 1'b1;
    repeat (B) @(negedge clk);
  endtask

  // issue one command; optionally pulse a second request busy_at clocks
  // after the first start bit
  task automatic tx_send(input logic [7:0] c, input logic [15:0] d, input int busy_at);
    int cnt;
    @(negedge clk);
    cmd = c;
    data = d;
    send_cmd = 1'b1;
    tx_exp_q.push_back(c);
    tx_exp_q.push_back(d[15:8]);
    tx_exp_q.push_back(d[7:0]);
    @(negedge clk);
    send_cmd = 1'b0;
    cmd = 8'($urandom);
    data = 16'($urandom);
    check("cmd_sent_clear", {31'd0, cmd_sent}, 32'd0);
    cnt = 1;
    while (TX !== 1'b0 && cnt < 8) begin
      @(negedge clk);
      cnt++;
    end
    check("tx_latency", cnt, 2);
    cnt = 0;
    while (cmd_sent !== 1'b1 && cnt < 32 * B) begin
      @(negedge clk);
      cnt++;
      if (busy_at != 0) begin
        if (cnt == busy_at) begin
          cmd = 8'h07;
          data = 16'($urandom);
          send_cmd = 1'b1;
        end else begin
          send_cmd = 1'b0;
        end
      end
    end
    send_cmd = 1'b0;
    check("cmd_sent_time", cnt, 30 * B);
    @(negedge clk);
    check("cmd_sent_hold", {31'd0, cmd_sent}, 32'd1);
  endtask

  int wcnt;
  int tcnt;

  initial begin
    // reset
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    check("rst_tx", {31'd0, TX}, 32'd1);
    check("rst_cmd_sent", {31'd0, cmd_sent}, 32'd0);
    check("rst_resp_rdy", {31'd0, resp_rdy}, 32'd0);
    check("rst_resp", {24'd0, resp}, 32'd0);
    rst_n = 1'b0;
    repeat (3) @(negedge clk);

    // thrust command
    tx_send(8'h05, 16'h00FF, 0);

    // roll command with an ignored mid-transfer request
    tx_send(8'h03, 16'hFF80, 12 * B);
    repeat (12 * B) @(negedge clk);
    check("busy_no_extra", tx_exp_q.size(), 0);
    check("busy_cmd_sent", {31'd0, cmd_sent}, 32'd1);

    // response receive and clear
    uart_send(8'hA5, 1);
    check("resp_rdy_set", {31'd0, resp_rdy}, 32'd1);
    @(negedge clk);
    clr_resp_rdy = 1'b1;
    @(negedge clk);
    clr_resp_rdy = 1'b0;
    check("resp_rdy_clr", {31'd0, resp_rdy}, 32'd0);
    check("resp_hold", {24'd0, resp}, 32'hA5);

    // concurrent traffic, clear held across the set cycle
    fork
      tx_send(8'h06, 16'h0000, 0);
      begin
        repeat (3 * B) @(negedge clk);
        uart_send(8'hA5, 1);
      end
      begin
        repeat (3 * B) @(negedge clk);
        clr_resp_rdy = 1'b1;
        wcnt = 0;
        while (resp_rdy !== 1'b1 && wcnt < 14 * B) begin
          @(negedge clk);
          wcnt++;
        end
        check("set_wins", {31'd0, resp_rdy}, 32'd1);
        clr_resp_rdy = 1'b0;
        @(negedge clk);
        check("set_wins_hold", {31'd0, resp_rdy}, 32'd1);
      end
    join

    // randomized commands with overlapping responses
    for (int n = 0; n < 6; n++) begin
      fork
        tx_send(8'($urandom), 16'($urandom), 0);
        begin
          repeat ($urandom_range(1, 8 * B)) @(negedge clk);
          uart_send(8'($urandom), 1);
        end
      join
      check("rand_resp_rdy", {31'd0, resp_rdy}, 32'd1);
    end

    // a new start bit clears a pending resp_rdy
    fork
      uart_send(8'h3C, 1);
      begin
        repeat (B) @(negedge clk);
        check("rdy_clr_on_start", {31'd0, resp_rdy}, 32'd0);
      end
    join
    check("resp_after_start", {31'd0, resp_rdy}, 32'd1);

    // reset in the middle of the second frame and of a reception
    fork
      begin
        @(negedge clk);
        cmd = 8'h09;
        data = 16'h0034;
        send_cmd = 1'b1;
        tx_exp_q.push_back(8'h09);
        tx_exp_q.push_back(8'h00);
        tx_exp_q.push_back(8'h34);
        @(negedge clk);
        send_cmd = 1'b0;
        tcnt = 0;
        while (TX !== 1'b0 && tcnt < 8) begin
          @(negedge clk);
          tcnt++;
        end
        repeat (15 * B) @(negedge clk);
        check("tx_low_pre_reset", {31'd0, TX}, 32'd0);
        #3 rst_n = 1'b1;
        #1 check("tx_async_reset", {31'd0, TX}, 32'd1);
      end
      begin
        repeat (12 * B) @(negedge clk);
        uart_send(8'h5A, 0);
      end
    join
    tx_exp_q.delete();
    @(negedge clk);
    check("mid_rst_cmd_sent", {31'd0, cmd_sent}, 32'd0);
    check("mid_rst_resp", {24'd0, resp}, 32'd0);
    rst_n = 1'b0;
    repeat (2 * B) @(negedge clk);
    check("rx_discard", {31'd0, resp_rdy}, 32'd0);
    tx_send(8'h0A, 16'hBEEF, 0);

    repeat (2 * B) @(negedge clk);
    check("tx_queue_empty", tx_exp_q.size(), 0);
    check("rx_queue_empty", rx_exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
